// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
// Issues in-order fetch requests from a 64-bit PC, pairs each response with the
// PC that requested it, and buffers up to two {inst, pc} pairs for decode.
// Redirects realign the PC, flush the buffer and drop responses still in flight.
// Optional build macro: IF_PERF_CNT_EN adds a 32-bit count of consumed instructions
// on output fetch_count.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned PTR_W  = 1;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned SUM_W  = 3;
    localparam logic [ILEN-1:0] NOP_INST  = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MSK = ~64'h3;
    localparam logic [XLEN-1:0] PC_START  = RESET_PC & ALIGN_MSK;

    // Architectural PC: address of the next request to issue
    logic [XLEN-1:0]  pc_q;

    // PCs of accepted requests awaiting their in-order responses
    logic [XLEN-1:0]  pend_pc_q [DEPTH];
    logic [PTR_W-1:0] pend_rd_q;
    logic [PTR_W-1:0] pend_wr_q;

    // Requests in flight, and how many of those must be discarded
    logic [CNT_W-1:0] outst_q;
    logic [CNT_W-1:0] drop_q;

    // Decode-side buffer of {inst, pc}
    logic [ILEN-1:0]  fifo_inst_q [DEPTH];
    logic [XLEN-1:0]  fifo_pc_q   [DEPTH];
    logic [PTR_W-1:0] fifo_rd_q;
    logic [PTR_W-1:0] fifo_wr_q;
    logic [CNT_W-1:0] fifo_cnt_q;

    logic [SUM_W-1:0] occ_sum;
    logic             req_fire;
    logic             resp_fire;
    logic             resp_keep;
    logic             pop;
    logic [XLEN-1:0]  resp_pc;

    // Handshake decode and decode-side view of the buffer head
    always_comb begin
        occ_sum        = SUM_W'(outst_q) + SUM_W'(fifo_cnt_q);
        imem_req_valid = !rst && !redirect_valid && (occ_sum < SUM_W'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        resp_fire      = imem_resp_valid && (outst_q != '0);
        resp_keep      = resp_fire && !redirect_valid && (drop_q == '0);
        resp_pc        = pend_pc_q[pend_rd_q];
        id_valid       = (fifo_cnt_q != '0);
        pop            = id_valid && id_ready;
        id_inst        = NOP_INST;
        id_pc          = '0;
        if (id_valid) begin
            id_inst = fifo_inst_q[fifo_rd_q];
            id_pc   = fifo_pc_q[fifo_rd_q];
        end
    end

    assign imem_req_addr = pc_q;

    // PC update: redirect wins over sequential advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_START;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & ALIGN_MSK;
        end else if (req_fire) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    // Track request PCs so each response is tagged with the PC that fetched it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pend_pc_q[i] <= '0;
            end
            pend_rd_q <= '0;
            pend_wr_q <= '0;
        end else begin
            if (req_fire) begin
                pend_pc_q[pend_wr_q] <= pc_q;
                pend_wr_q            <= pend_wr_q + PTR_W'(1);
            end
            if (resp_fire) begin
                pend_rd_q <= pend_rd_q + PTR_W'(1);
            end
        end
    end

    // Outstanding and drop counters; a redirect marks everything in flight as stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            outst_q <= outst_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
            if (redirect_valid) begin
                drop_q <= outst_q - CNT_W'(resp_fire);
            end else if (resp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - CNT_W'(1);
            end
        end
    end

    // Decode buffer: push kept responses, pop on consume, flush on redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_inst_q[i] <= NOP_INST;
                fifo_pc_q[i]   <= '0;
            end
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
        end else if (redirect_valid) begin
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (resp_keep) begin
                fifo_inst_q[fifo_wr_q] <= imem_resp_data;
                fifo_pc_q[fifo_wr_q]   <= resp_pc;
                fifo_wr_q              <= fifo_wr_q + PTR_W'(1);
            end
            if (pop) begin
                fifo_rd_q <= fifo_rd_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(resp_keep) - CNT_W'(pop);
        end
    end

`ifdef IF_PERF_CNT_EN
    // Count instructions handed to decode (wraps)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage with an in-order memory model and
// a scoreboard of {inst, pc} pairs expected at the decode side.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    if_stage #(.RESET_PC(64'h1000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests;
    int unsigned failed;
    int unsigned drop_n;
    int unsigned fc_exp;
    logic [63:0] exp_pc;
    logic [63:0] inflight[$];
    logic [95:0] exp_q[$];
    logic [63:0] addr_log[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive, sample after settling, update model, advance
    task automatic cycle(input logic rdy, input logic rq_rdy, input logic redir,
                         input logic [63:0] rpc, input logic mem_en);
        logic        exp_rv;
        logic [95:0] e;
        logic [63:0] a;
        id_ready       = rdy;
        imem_req_ready = rq_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_en && inflight.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(inflight[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        exp_rv = !redir && ((inflight.size() + exp_q.size()) < 2);
        check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        check("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
`ifdef IF_PERF_CNT_EN
        check("fetch_count", 64'(fetch_count), 64'(fc_exp));
`endif
        if (id_valid && id_ready) begin
            fc_exp++;
            if (exp_q.size() == 0) begin
                check("spurious_id", 64'(id_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e[63:0]);
                check("id_inst", 64'(id_inst), 64'(e[95:64]));
            end
        end
        if (redir) begin
            exp_q.delete();
            drop_n = inflight.size();
            exp_pc = rpc & ~64'h3;
        end
        if (imem_resp_valid) begin
            a = inflight.pop_front();
            if (drop_n > 0) drop_n--;
            else exp_q.push_back({mem_word(a), a});
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            inflight.push_back(imem_req_addr);
            addr_log.push_back(imem_req_addr);
            exp_pc = exp_pc + 64'd4;
        end
        @(posedge clk);
        #1;
    endtask

    // Stop issuing, let responses land and be consumed, then confirm all arrived
    task automatic drain();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
        check("drain_left", 64'(exp_q.size()), 64'h0);
        check("drain_idle", 64'(id_valid), 64'h0);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        id_ready        = 1'b0;
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("rst_id_valid", 64'(id_valid), 64'h0);
        check("rst_id_inst", 64'(id_inst), 64'h13);
        check("rst_id_pc", id_pc, 64'h0);
        check("rst_req_addr", imem_req_addr, 64'h1000);
`ifdef IF_PERF_CNT_EN
        check("rst_fetch_count", 64'(fetch_count), 64'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        inflight.delete();
        exp_q.delete();
        addr_log.delete();
        drop_n = 0;
        fc_exp = 0;
        exp_pc = 64'h1000;
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // Reset and plain sequential fetch from RESET_PC
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        check("seq_log_size", 64'(addr_log.size() >= 3), 64'h1);
        if (addr_log.size() >= 3) begin
            check("seq_addr0", addr_log[0], 64'h1000);
            check("seq_addr1", addr_log[1], 64'h1004);
            check("seq_addr2", addr_log[2], 64'h1008);
        end
        drain();

        // Decode backpressure fills the buffer and stalls fetch
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
        check("bp_full_valid", 64'(id_valid), 64'h1);
        check("bp_req_stalled", 64'(imem_req_valid), 64'h0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        drain();

        // Redirect with two requests in flight; both late responses are dropped
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        check("redir_two_outst", 64'(inflight.size()), 64'h2);
        addr_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 64'h2002, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        check("redir_log_size", 64'(addr_log.size() >= 1), 64'h1);
        if (addr_log.size() >= 1) check("redir_first_addr", addr_log[0], 64'h2000);
        drain();

        // Redirect coinciding with a response: that response is dropped
        cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 64'h3000, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        drain();

        // PC wrap at the top of the address space
        addr_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        check("wrap_log_size", 64'(addr_log.size() >= 2), 64'h1);
        if (addr_log.size() >= 2) begin
            check("wrap_addr0", addr_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_addr1", addr_log[1], 64'h0);
        end
        drain();

        // Reset in the middle of outstanding fetches abandons them
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
